sha1_pipe_sched: RTL and testbench
==================================

Name: sha1_pipe_sched

Overview:
Sequencer for the 4-stage SHA-1 compression pipeline (`op`). It accepts 512-bit chunk jobs tagged with one of 4 hash slots and holds each job in a 1-entry pending register. It advances jobs through the 4 stages in lock-step 20-round epochs and drives the pipeline control strobes. It returns a completion tag when the pipeline's writeback finishes; message words come from an external schedule, indexed by the per-stage round outputs.

Parameters:
ROUNDS_PER_STAGE, 20, rounds each stage executes per epoch (4 x 20 = 80 SHA-1 rounds).
NSLOT, 4, number of hash contexts; fixed to match the 2-bit slot fields.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
chunk_valid  in  1  job offered
chunk_ready  out  1  pending register empty; job accepted when valid&ready
chunk_slot  in  2  hash slot of offered job
chunk_first  in  1  job is first chunk of its message (reinit slot hash)
feed  out  4  per-stage load strobe to pipeline
next  out  4  per-stage round-advance enable to pipeline
msgIn_cnt  out  2  slot of job in stage 0
msgOut_cnt  out  2  slot being written back
finalStage  out  1  stage-3 last-round strobe
first_chunk  out  1  first flag of job in stage 0
op_ready  in  1  pipeline writeback-complete (pipeline `ready`)
round0..round3  out  7 each  global round index (0..79) of stage k, for W lookup
done_valid  out  1  one-cycle completion pulse
done_slot  out  2  slot completed; valid with done_valid
busy  out  4  per-slot in-flight bitmap
idle  out  1  no pending, in-flight or writeback job

Behaviour:
- Reset (async): pending, stage valid/slot/first, busy, round counter r, epoch-run flag, wb_slot and done_valid all cleared. chunk_ready=1, feed=next=0, finalStage=0, msgIn_cnt=msgOut_cnt=0, idle=1.
- Reset mid-operation discards every job; no done pulse is ever issued for discarded jobs.
- Intake: chunk_ready = !pend_v (registered, independent of chunk_slot).
  - On accept, pend_{v,slot,first} are loaded.
- Epoch counter r runs 0..ROUNDS_PER_STAGE-1 while running.
  - Running starts the cycle after pend_v becomes 1 with the pipeline empty.
  - Running stops after r=19 when no stage is valid and pend_v=0.
- Boundary (the transition into r=0):
  - stage3 retires; stage2->3, 1->2, 0->1.
  - stage0 loads the pending job if busy[pend_slot]=0, then clears pend_v and sets busy[pend_slot].
  - Otherwise stage0 is a bubble (invalid) and the pending job retries at the next boundary.
- Outputs, all registered and decoded from r and the stage valid bits:
  - feed[k]=1 in the r=0 cycle if stage k is valid.
  - next[k]=1 for r=1..19 if stage k is valid.
  - round_k = 20*k + r, and 0 when stage k is invalid.
- msgIn_cnt and first_chunk = stage0 slot and first flag, held the whole epoch (covers the registered feed[0] inside `op`).
  - first_chunk=0 when stage0 is invalid.
- Writeback:
  - finalStage=1 in the r=19 cycle when stage3 is valid (cycle F).
  - wb_slot <= stage3 slot at F.
  - msgOut_cnt = wb_slot, held until op_ready is seen; F+1 = `op` writes hash, F+2 = op_ready.
- Completion: when op_ready=1, done_valid=1 next cycle with done_slot=wb_slot, and busy[wb_slot] is cleared in that same edge.
  - The boundary busy check uses registered busy, so a clear and a check in the same cycle resolve to busy.
- Latency: accept at cycle 0 into an idle pipe gives feed[0] at 1, finalStage at 80, op_ready at 82, done_valid at 83.
- Throughput: one job per 20 cycles with 4 distinct slots.
  - Back-to-back chunks of the same slot serialize: the second loads at the first boundary after the first's done.
- op_ready without an outstanding writeback is ignored.
- A second finalStage cannot precede op_ready: they are 20 cycles apart by construction.
- idle = !pend_v & no stage valid & busy==0.

Decomposition:
- Shared package sha1_pkg: ROUNDS_PER_STAGE, NSTAGE=4, NSLOT=4, a slot_t 2-bit typedef, and a stage-entry struct {valid, slot, first}.
- One sub-module: sha1_epoch_ctr, holding the round counter, run/stop control and boundary strobe.
- Stage shifting, busy tracking and writeback stay in the top.

Test Plan:
- Single job slot 2, first=1, accepted cycle 0 -> feed=0001 at 1, msgIn_cnt=2 and first_chunk=1 for cycles 1-20, finalStage at 80, msgOut_cnt=2, op_ready at 82 -> done_valid/done_slot=2 at 83, idle=1 afterwards.
- Four jobs, slots 0,1,2,3 offered back-to-back -> feed[0] at cycles 1,21,41,61; feed=1111 at 61; done slots 0,1,2,3 at 83,103,123,143.
- Two jobs same slot 1 -> second stays pending with chunk_ready=0; bubbles fill stage0 (feed[0]=0 at 21,41,61,81); second loads at first boundary after done (cycle 101).
- Job slot 0 then slot 0 again with a slot-3 job interleaved -> slot 3 cannot bypass the pending slot-0 job (in-order intake); verify order and busy bitmap.
- Reset asserted at cycle 45 with 3 jobs in flight -> all outputs at reset values immediately, no done_valid, fresh job after reset completes normally in 83 cycles.
- Spurious op_ready while idle -> no done_valid, busy unchanged.

Source files
------------

// File: rtl/sha1_pkg.sv
// Shared types and constants for the SHA-1 pipeline sequencer.
package sha1_pkg;
  localparam int unsigned ROUNDS_PER_STAGE = 20;
  localparam int unsigned NSTAGE           = 4;
  localparam int unsigned NSLOT            = 4;

  typedef logic [1:0] slot_t;

  typedef struct packed {
    logic  valid;
    slot_t slot;
    logic  first;
  } stage_t;

  typedef enum logic {
    EP_STOP = 1'b0,
    EP_RUN  = 1'b1
  } ep_state_t;
endpackage

// File: rtl/sha1_pipe_sched_if.sv
// Chunk-job intake handshake between a job producer and the sequencer.
interface sha1_pipe_sched_if;
  import sha1_pkg::*;

  logic  chunk_valid;
  logic  chunk_ready;
  slot_t chunk_slot;
  logic  chunk_first;

  modport master (output chunk_valid, output chunk_slot, output chunk_first, input chunk_ready);
  modport slave  (input chunk_valid, input chunk_slot, input chunk_first, output chunk_ready);
endinterface

// File: rtl/sha1_epoch_ctr.sv
// Epoch round counter: runs 0..ROUNDS_PER_STAGE-1 and strobes adv on every
// transition into round 0 (including the final drain step that stops it).
module sha1_epoch_ctr #(
  parameter int unsigned ROUNDS_PER_STAGE = sha1_pkg::ROUNDS_PER_STAGE
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                pend_v,
  input  logic                                live,
  output logic                                adv,
  output logic                                run_nxt,
  output logic [$clog2(ROUNDS_PER_STAGE)-1:0] r_nxt
);
  import sha1_pkg::*;

  localparam int unsigned   RW   = $clog2(ROUNDS_PER_STAGE);
  localparam logic [RW-1:0] LAST = RW'(ROUNDS_PER_STAGE - 1);

  ep_state_t     state_q, state_d;
  logic [RW-1:0] r_q;

  always_comb begin
    state_d = state_q;
    adv     = 1'b0;
    r_nxt   = r_q;
    case (state_q)
      EP_STOP: begin
        if (pend_v) begin
          adv     = 1'b1;
          state_d = EP_RUN;
          r_nxt   = '0;
        end
      end
      EP_RUN: begin
        if (r_q == LAST) begin
          // still advance when stopping so the last stage retires
          adv   = 1'b1;
          r_nxt = '0;
          if (!(live || pend_v)) state_d = EP_STOP;
        end else begin
          r_nxt = r_q + 1'b1;
        end
      end
      default: state_d = EP_STOP;
    endcase
  end

  assign run_nxt = (state_d == EP_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EP_STOP;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_nxt;
    end
  end
endmodule

// File: rtl/sha1_pipe_sched.sv
// SHA-1 pipeline sequencer: pending-job intake, lock-step stage shifting,
// per-slot busy tracking and writeback/completion handling.
module sha1_pipe_sched #(
  parameter int unsigned ROUNDS_PER_STAGE = sha1_pkg::ROUNDS_PER_STAGE
) (
  input  logic                    clk,
  input  logic                    reset,
  sha1_pipe_sched_if.slave        chunk,
  output logic [3:0]              feed,
  output logic [3:0]              next,
  output logic [1:0]              msgIn_cnt,
  output logic [1:0]              msgOut_cnt,
  output logic                    finalStage,
  output logic                    first_chunk,
  input  logic                    op_ready,
  output logic [6:0]              round0,
  output logic [6:0]              round1,
  output logic [6:0]              round2,
  output logic [6:0]              round3,
  output logic                    done_valid,
  output logic [1:0]              done_slot,
  output logic [3:0]              busy,
  output logic                    idle
);
  import sha1_pkg::*;

  localparam int unsigned   RW   = $clog2(ROUNDS_PER_STAGE);
  localparam logic [RW-1:0] LAST = RW'(ROUNDS_PER_STAGE - 1);

  stage_t           stg_q [NSTAGE];
  stage_t           stg_d [NSTAGE];
  logic             pend_v, pend_v_d, pend_first, pend_first_d;
  slot_t            pend_slot, pend_slot_d;
  logic [NSLOT-1:0] busy_d;
  logic             wb_pend, wb_pend_d;
  slot_t            wb_slot, wb_slot_d;
  logic             done_d, fin_d, idle_d, load, live, any_v;
  logic             adv, run_nxt;
  logic [RW-1:0]    r_nxt;
  logic [3:0]       feed_d, next_d;
  logic [6:0]       round_d [NSTAGE];
  logic [6:0]       round_q [NSTAGE];

  assign chunk.chunk_ready = ~pend_v;
  assign live              = stg_q[0].valid | stg_q[1].valid | stg_q[2].valid;
  assign msgOut_cnt        = wb_slot;
  assign round0            = round_q[0];
  assign round1            = round_q[1];
  assign round2            = round_q[2];
  assign round3            = round_q[3];

  sha1_epoch_ctr #(.ROUNDS_PER_STAGE(ROUNDS_PER_STAGE)) u_ctr (
    .clk     (clk),
    .rst     (reset),
    .pend_v  (pend_v),
    .live    (live),
    .adv     (adv),
    .run_nxt (run_nxt),
    .r_nxt   (r_nxt)
  );

  // Outputs are registered from next-state values so they line up with r.
  always_comb begin
    stg_d        = stg_q;
    pend_v_d     = pend_v;
    pend_slot_d  = pend_slot;
    pend_first_d = pend_first;
    busy_d       = busy;
    any_v        = 1'b0;
    load         = adv & pend_v & ~busy[pend_slot];

    if (adv) begin
      for (int unsigned k = 1; k < NSTAGE; k++) stg_d[k] = stg_q[k-1];
      stg_d[0] = load ? stage_t'{valid: 1'b1, slot: pend_slot, first: pend_first} : '0;
    end

    if (load) begin
      pend_v_d = 1'b0;
    end else if (chunk.chunk_valid && !pend_v) begin
      pend_v_d     = 1'b1;
      pend_slot_d  = chunk.chunk_slot;
      pend_first_d = chunk.chunk_first;
    end

    done_d = op_ready & wb_pend;
    if (done_d) busy_d[wb_slot] = 1'b0;
    if (load)   busy_d[pend_slot] = 1'b1;

    fin_d     = run_nxt & (r_nxt == LAST) & stg_d[3].valid;
    wb_pend_d = fin_d ? 1'b1 : (done_d ? 1'b0 : wb_pend);
    wb_slot_d = fin_d ? stg_d[3].slot : wb_slot;

    for (int unsigned k = 0; k < NSTAGE; k++) begin
      feed_d[k]  = run_nxt & (r_nxt == '0) & stg_d[k].valid;
      next_d[k]  = run_nxt & (r_nxt != '0) & stg_d[k].valid;
      round_d[k] = stg_d[k].valid ? 7'(k * ROUNDS_PER_STAGE + r_nxt) : '0;
      any_v      = any_v | stg_d[k].valid;
    end

    idle_d = ~pend_v_d & ~any_v & (busy_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < NSTAGE; k++) begin
        stg_q[k]   <= '0;
        round_q[k] <= '0;
      end
      pend_v      <= 1'b0;
      pend_slot   <= '0;
      pend_first  <= 1'b0;
      busy        <= '0;
      wb_pend     <= 1'b0;
      wb_slot     <= '0;
      done_valid  <= 1'b0;
      done_slot   <= '0;
      feed        <= '0;
      next        <= '0;
      finalStage  <= 1'b0;
      msgIn_cnt   <= '0;
      first_chunk <= 1'b0;
      idle        <= 1'b1;
    end else begin
      for (int unsigned k = 0; k < NSTAGE; k++) begin
        stg_q[k]   <= stg_d[k];
        round_q[k] <= round_d[k];
      end
      pend_v      <= pend_v_d;
      pend_slot   <= pend_slot_d;
      pend_first  <= pend_first_d;
      busy        <= busy_d;
      wb_pend     <= wb_pend_d;
      wb_slot     <= wb_slot_d;
      done_valid  <= done_d;
      if (done_d) done_slot <= wb_slot;
      feed        <= feed_d;
      next        <= next_d;
      finalStage  <= fin_d;
      msgIn_cnt   <= stg_d[0].slot;
      first_chunk <= stg_d[0].first;
      idle        <= idle_d;
    end
  end
endmodule

// File: tb/tb_sha1_pipe_sched.sv
// Scoreboard bench for sha1_pipe_sched: a job-timeline reference model predicts
// every output per cycle and the completion order/time of each job.
module tb_sha1_pipe_sched;
  import sha1_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] feed, next, busy;
  logic [1:0] msgIn_cnt, msgOut_cnt, done_slot;
  logic       finalStage, first_chunk, op_ready, done_valid, idle;
  logic [6:0] round0, round1, round2, round3;
  logic       fs_d1, pipe_rdy, spur;

  sha1_pipe_sched_if cif();

  sha1_pipe_sched #(.ROUNDS_PER_STAGE(20)) dut (
    .clk(clk), .reset(reset), .chunk(cif),
    .feed(feed), .next(next), .msgIn_cnt(msgIn_cnt), .msgOut_cnt(msgOut_cnt),
    .finalStage(finalStage), .first_chunk(first_chunk), .op_ready(op_ready),
    .round0(round0), .round1(round1), .round2(round2), .round3(round3),
    .done_valid(done_valid), .done_slot(done_slot), .busy(busy), .idle(idle)
  );

  always #5 clk = ~clk;

  // Pipeline stub: hash written at F+1, op_ready at F+2.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      fs_d1    <= 1'b0;
      pipe_rdy <= 1'b0;
    end else begin
      fs_d1    <= finalStage;
      pipe_rdy <= fs_d1;
    end
  end
  assign op_ready = pipe_rdy | spur;

  // ---------------- reference model ----------------
  typedef struct { int L; int slot; bit first; } job_t;
  typedef struct { int slot; int t; } exp_t;
  job_t jobs[$];
  exp_t sb[$];
  int   cyc;
  bit   m_pend, m_pfirst, m_run;
  int   m_pslot, m_last;
  int   checks = 0, errors = 0;

  function automatic bit slot_busy(input int s, input int t);
    foreach (jobs[i]) if (jobs[i].slot == s && t - jobs[i].L >= 0 && t - jobs[i].L <= 81) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or posedge reset) begin
    int c; bit bnd, acc, infl;
    if (reset) begin
      cyc = 0; jobs.delete(); sb.delete(); m_pend = 0; m_run = 0; m_last = 0;
    end else begin
      cyc++; c = cyc; bnd = 0;
      acc = !m_pend && cif.chunk_valid;
      if (!m_run) begin
        if (m_pend) begin bnd = 1; m_run = 1; end
      end else if (c == m_last + 20) begin
        infl = 0;
        foreach (jobs[i]) if (c - 1 - jobs[i].L < 60) infl = 1;
        if (infl || m_pend) bnd = 1; else m_run = 0;
      end
      if (bnd) begin
        m_last = c;
        if (m_pend && !slot_busy(m_pslot, c - 1)) begin
          jobs.push_back('{L: c, slot: m_pslot, first: m_pfirst});
          sb.push_back('{slot: m_pslot, t: c + 82});
          m_pend = 0;
        end
      end
      if (acc) begin m_pend = 1; m_pslot = int'(cif.chunk_slot); m_pfirst = cif.chunk_first; end
      while (jobs.size() > 0 && c - jobs[0].L > 82) void'(jobs.pop_front());
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    int d, k, e_fs, e_fc, e_mi, e_mo;
    int e_round[4];
    logic [3:0] e_feed, e_next, e_busy;
    exp_t e;
    #1;
    e_feed = '0; e_next = '0; e_busy = '0; e_fs = 0; e_fc = 0; e_mi = -1; e_mo = -1;
    for (int i = 0; i < 4; i++) e_round[i] = 0;
    foreach (jobs[i]) begin
      d = cyc - jobs[i].L;
      if (d >= 0 && d < 80) begin
        k = d / 20;
        if (d % 20 == 0) e_feed[k] = 1'b1; else e_next[k] = 1'b1;
        e_round[k] = d;
        if (d == 79) e_fs = 1;
        if (k == 0) begin e_mi = jobs[i].slot; e_fc = int'(jobs[i].first); end
      end
      if (d >= 79 && d <= 81) e_mo = jobs[i].slot;
      if (d >= 0 && d <= 81) e_busy[jobs[i].slot] = 1'b1;
    end
    chk("feed", int'(feed), int'(e_feed));
    chk("next", int'(next), int'(e_next));
    chk("round0", int'(round0), e_round[0]);
    chk("round1", int'(round1), e_round[1]);
    chk("round2", int'(round2), e_round[2]);
    chk("round3", int'(round3), e_round[3]);
    chk("finalStage", int'(finalStage), e_fs);
    chk("first_chunk", int'(first_chunk), e_fc);
    chk("busy", int'(busy), int'(e_busy));
    chk("chunk_ready", int'(cif.chunk_ready), int'(!m_pend));
    chk("idle", int'(idle), int'(!m_pend && e_busy == 4'd0));
    if (e_mi >= 0) chk("msgIn_cnt", int'(msgIn_cnt), e_mi);
    if (e_mo >= 0) chk("msgOut_cnt", int'(msgOut_cnt), e_mo);
    if (done_valid) begin
      if (sb.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        e = sb.pop_front();
        chk("done_slot", int'(done_slot), e.slot);
        chk("done_cycle", cyc, e.t);
      end
    end else if (sb.size() > 0 && sb[0].t <= cyc) begin
      chk("done_missing", 0, 1);
      void'(sb.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int slot, input bit first);
    int n = 0;
    @(negedge clk);
    cif.chunk_valid = 1'b1;
    cif.chunk_slot  = 2'(slot);
    cif.chunk_first = first;
    while (!cif.chunk_ready && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) chk("accept_timeout", 0, 1);
    @(negedge clk);
    cif.chunk_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((m_pend || sb.size() > 0) && n < 600) begin @(negedge clk); n++; end
    if (n >= 600) chk("drain_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_feed", int'(feed), 0);
    chk("rst_next", int'(next), 0);
    chk("rst_finalStage", int'(finalStage), 0);
    chk("rst_done_valid", int'(done_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_idle", int'(idle), 1);
    chk("rst_chunk_ready", int'(cif.chunk_ready), 1);
    chk("rst_msgIn_cnt", int'(msgIn_cnt), 0);
    chk("rst_msgOut_cnt", int'(msgOut_cnt), 0);
    chk("rst_round3", int'(round3), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int start, n;
    reset = 1'b1; spur = 1'b0;
    cif.chunk_valid = 1'b0; cif.chunk_slot = '0; cif.chunk_first = 1'b0;
    do_reset();

    send(2, 1'b1); drain();
    for (int s = 0; s < 4; s++) send(s, s[0]);
    drain();
    send(1, 1'b1); send(1, 1'b0); drain();
    send(0, 1'b1); send(0, 1'b0); send(3, 1'b1); drain();

    start = cyc;
    send(0, 1'b1); send(1, 1'b0); send(2, 1'b1);
    n = 0;
    while (cyc < start + 45 && n < 100) begin @(negedge clk); n++; end
    do_reset();
    send(3, 1'b1); drain();

    @(negedge clk); spur = 1'b1;
    @(negedge clk); spur = 1'b0;
    repeat (5) @(negedge clk);

    for (int j = 0; j < 60; j++) begin
      send(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 25)) @(negedge clk);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule
